picosoc_bus_arbiter: RTL and testbench

- Two-master arbiter for the PicoSoC native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Master 0 is the PicoRV32 core and master 1 is a DMA/debug master. Both share one downstream slave port, which feeds the existing address decode (RAM, spimemio, UART, iomem).
- Round-robin arbitration, one granted transaction at a time, with a bus-timeout watchdog that terminates hung slave accesses.

---
 rtl/picosoc_pkg.sv | 16 +
 rtl/picosoc_bus_watchdog.sv | 52 +++++
 rtl/picosoc_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_picosoc_bus_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/picosoc_pkg.sv
// rtl/picosoc_pkg.sv - shared FSM encoding and bus defaults for the PicoSoC bus arbiter
//
// Purpose : state encoding shared by the arbiter FSM, and the default
//           read data returned on a watchdog-forced completion.
// Ports   : none (package).
package picosoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/picosoc_bus_watchdog.sv
// rtl/picosoc_bus_watchdog.sv - bus-timeout watchdog for one owned transaction
//
// Purpose : counts wait cycles of the owned access and flags the cycle in
//           which it must be force-completed; latches the timed-out address.
// Ports   : clk, reset       - clock, synchronous active-high reset
//           active           - owned request waiting on the slave this cycle
//           done             - owned transaction ends (completion or abort)
//           addr             - address of the owned access
//           expire           - force completion this cycle (combinational)
//           timeout_irq      - one-cycle pulse after a forced completion
//           timeout_addr     - address of the most recent timed-out access
module picosoc_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic        done,
    input  logic [31:0] addr,
    output logic        expire,
    output logic        timeout_irq,
    output logic [31:0] timeout_addr
);

    localparam bit               WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // active already excludes s_ready, so a late s_ready always wins over expiry.
    assign expire = WD_EN && active && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            timeout_irq  <= 1'b0;
            timeout_addr <= '0;
        end else begin
            if (!WD_EN || !active || done || expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            timeout_irq <= expire;
            if (expire) begin
                timeout_addr <= addr;
            end
        end
    end

endmodule

// File: rtl/picosoc_bus_arbiter.sv
// rtl/picosoc_bus_arbiter.sv - two-master round-robin arbiter for the PicoSoC native bus
//
// Purpose : grants one of two masters (0 = core, 1 = DMA/debug) to the shared
//           slave port, one transaction at a time, with a timeout watchdog.
// Ports   : clk, reset                          - clock, sync active-high reset
//           m0_* / m1_*                         - master request/response ports
//           s_valid/instr/addr/wdata/wstrb      - downstream request
//           s_ready, s_rdata                    - downstream response
//           s_owner                             - granted master index
//           timeout_irq, timeout_addr           - watchdog event and address
module picosoc_bus_arbiter
    import picosoc_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = TIMEOUT_RDATA_DEFAULT,
    parameter int          CNT_W          = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        s_owner,
    output logic        timeout_irq,
    output logic [31:0] timeout_addr
);

    arb_state_t  state;
    logic        last;
    logic        own0;
    logic        own1;
    logic        wd_active;
    logic        wd_done;
    logic        expire;
    logic [31:0] resp_data;

    assign own0 = (state == ST_OWN0);
    assign own1 = (state == ST_OWN1);

    always_comb begin
        s_valid = 1'b0;
        s_instr = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        if (own0) begin
            s_valid = m0_valid;
            s_instr = m0_instr;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
        end else if (own1) begin
            s_valid = m1_valid;
            s_instr = m1_instr;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
        end
    end

    assign s_owner   = own1;
    assign wd_active = s_valid && !s_ready;
    // A dropped request while owned (abort) also ends the transaction.
    assign wd_done   = (own0 || own1) && (!s_valid || s_ready);

    assign m0_ready  = own0 && ((s_valid && s_ready) || expire);
    assign m1_ready  = own1 && ((s_valid && s_ready) || expire);
    assign resp_data = s_ready ? s_rdata : TIMEOUT_RDATA;
    assign m0_rdata  = m0_ready ? resp_data : '0;
    assign m1_rdata  = m1_ready ? resp_data : '0;

    picosoc_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk          (clk),
        .reset        (reset),
        .active       (wd_active),
        .done         (wd_done),
        .addr         (s_addr),
        .expire       (expire),
        .timeout_irq  (timeout_irq),
        .timeout_addr (timeout_addr)
    );

    // Every transaction returns through IDLE, which keeps the slave from seeing
    // a back-to-back request right after a forced completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_valid && m1_valid) begin
                        state <= last ? ST_OWN0 : ST_OWN1;
                    end else if (m0_valid) begin
                        state <= ST_OWN0;
                    end else if (m1_valid) begin
                        state <= ST_OWN1;
                    end
                end
                ST_OWN0: begin
                    if (m0_ready) begin
                        state <= ST_IDLE;
                        last  <= 1'b0;
                    end else if (!m0_valid) begin
                        state <= ST_IDLE;
                    end
                end
                ST_OWN1: begin
                    if (m1_ready) begin
                        state <= ST_IDLE;
                        last  <= 1'b1;
                    end else if (!m1_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// tb/tb_picosoc_bus_arbiter.sv - directed self-checking bench for picosoc_bus_arbiter
module tb_picosoc_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready, s_owner;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        timeout_irq;
    logic [31:0] timeout_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    picosoc_bus_arbiter #(
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_RDATA  (32'hDEAD_BEEF),
        .CNT_W          (11)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m0_valid     (m0_valid),
        .m0_instr     (m0_instr),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_wstrb     (m0_wstrb),
        .m0_ready     (m0_ready),
        .m0_rdata     (m0_rdata),
        .m1_valid     (m1_valid),
        .m1_instr     (m1_instr),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_wstrb     (m1_wstrb),
        .m1_ready     (m1_ready),
        .m1_rdata     (m1_rdata),
        .s_valid      (s_valid),
        .s_instr      (s_instr),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_ready      (s_ready),
        .s_rdata      (s_rdata),
        .s_owner      (s_owner),
        .timeout_irq  (timeout_irq),
        .timeout_addr (timeout_addr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        settle();
        check_eq("rst_s_valid", 32'(s_valid), 0);
        check_eq("rst_m0_ready", 32'(m0_ready), 0);
        check_eq("rst_m1_ready", 32'(m1_ready), 0);
        check_eq("rst_irq", 32'(timeout_irq), 0);
        check_eq("rst_taddr", timeout_addr, 0);

        // m0 read, slave answers on the third s_valid cycle
        m0_valid = 1; m0_addr = 32'h0000_0010; m0_wstrb = 0;
        settle();
        check_eq("t1_arb_cycle_s_valid", 32'(s_valid), 0);
        tick();
        check_eq("t1_s_valid", 32'(s_valid), 1);
        check_eq("t1_s_owner", 32'(s_owner), 0);
        check_eq("t1_s_addr", s_addr, 32'h0000_0010);
        check_eq("t1_m0_ready_early", 32'(m0_ready), 0);
        tick();
        check_eq("t1_m0_ready_wait", 32'(m0_ready), 0);
        tick();
        s_ready = 1; s_rdata = 32'h1234_5678;
        settle();
        check_eq("t1_m0_ready", 32'(m0_ready), 1);
        check_eq("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        check_eq("t1_m1_ready", 32'(m1_ready), 0);
        check_eq("t1_m1_rdata", m1_rdata, 0);
        tick();
        m0_valid = 0; s_ready = 0; s_rdata = 0;
        settle();
        check_eq("t1_after_s_valid", 32'(s_valid), 0);
        check_eq("t1_after_m0_ready", 32'(m0_ready), 0);

        // simultaneous requests right after reset: m0 wins the first tie
        do_reset();
        m0_valid = 1; m0_addr = 32'h0200_0008; m0_wdata = 32'hA5A5_A5A5; m0_wstrb = 4'hF;
        m1_valid = 1; m1_addr = 32'h0010_0000; m1_wstrb = 4'h0;
        tick();
        check_eq("t2_owner0", 32'(s_owner), 0);
        check_eq("t2_s_valid0", 32'(s_valid), 1);
        check_eq("t2_wstrb0", 32'(s_wstrb), 32'hF);
        check_eq("t2_wdata0", s_wdata, 32'hA5A5_A5A5);
        s_ready = 1;
        settle();
        check_eq("t2_m0_ready", 32'(m0_ready), 1);
        check_eq("t2_m1_ready_blocked", 32'(m1_ready), 0);
        tick();
        m0_valid = 0; s_ready = 0;
        settle();
        check_eq("t2_idle_gap", 32'(s_valid), 0);
        tick();
        check_eq("t2_owner1", 32'(s_owner), 1);
        check_eq("t2_addr1", s_addr, 32'h0010_0000);
        check_eq("t2_wstrb1", 32'(s_wstrb), 0);
        s_ready = 1; s_rdata = 32'h0000_5555;
        settle();
        check_eq("t2_m1_ready", 32'(m1_ready), 1);
        check_eq("t2_m1_rdata", m1_rdata, 32'h0000_5555);
        check_eq("t2_m0_ready_blocked", 32'(m0_ready), 0);
        tick();
        m1_valid = 0; s_ready = 0; s_rdata = 0;

        // both masters saturate the bus: grants alternate starting with m0
        m0_valid = 1; m0_wstrb = 0; m1_valid = 1; s_ready = 1; s_rdata = 32'h0000_00AA;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("t3_owner_%0d", i), 32'(s_owner), 32'(i % 2));
            check_eq($sformatf("t3_ready_%0d", i),
                     32'({m1_ready, m0_ready}), (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            check_eq($sformatf("t3_gap_%0d", i), 32'(s_valid), 0);
        end
        m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = 0;
        tick();

        // m1 read to a hung slave: forced completion on the 8th s_valid cycle
        m1_valid = 1; m1_addr = 32'h0300_0000; m1_wstrb = 0;
        tick();
        for (int j = 1; j <= 8; j++) begin
            check_eq($sformatf("t4_s_valid_%0d", j), 32'(s_valid), 1);
            check_eq($sformatf("t4_m1_ready_%0d", j), 32'(m1_ready), (j == 8) ? 32'd1 : 32'd0);
            check_eq($sformatf("t4_irq_%0d", j), 32'(timeout_irq), 0);
            if (j == 8) check_eq("t4_rdata", m1_rdata, 32'hDEAD_BEEF);
            if (j < 8) tick();
        end
        tick();
        m1_valid = 0;
        settle();
        check_eq("t4_irq", 32'(timeout_irq), 1);
        check_eq("t4_taddr", timeout_addr, 32'h0300_0000);
        check_eq("t4_idle", 32'(s_valid), 0);
        tick();
        check_eq("t4_irq_drop", 32'(timeout_irq), 0);

        // s_ready on the timeout cycle is a normal completion
        m0_valid = 1; m0_addr = 32'h0000_0004; m0_wstrb = 0;
        tick();
        for (int j = 1; j < 8; j++) tick();
        s_ready = 1; s_rdata = 32'h0000_0042;
        settle();
        check_eq("t5_m0_ready", 32'(m0_ready), 1);
        check_eq("t5_m0_rdata", m0_rdata, 32'h0000_0042);
        tick();
        m0_valid = 0; s_ready = 0; s_rdata = 0;
        settle();
        check_eq("t5_no_irq", 32'(timeout_irq), 0);
        check_eq("t5_taddr_kept", timeout_addr, 32'h0300_0000);
        tick();

        // reset while m0 waits on the slave
        m0_valid = 1; m0_addr = 32'h0000_0020;
        tick();
        tick();
        tick();
        check_eq("t6_owned", 32'(s_valid), 1);
        reset = 1;
        tick();
        reset = 0;
        settle();
        check_eq("t6_s_valid", 32'(s_valid), 0);
        check_eq("t6_m0_ready", 32'(m0_ready), 0);
        check_eq("t6_taddr_rst", timeout_addr, 0);
        m1_valid = 1; m1_addr = 32'h0000_0030;
        tick();
        check_eq("t6_tie_owner", 32'(s_owner), 0);
        // counter restarted: a full 8 wait cycles before expiry
        for (int j = 1; j < 8; j++) begin
            check_eq($sformatf("t6_wait_%0d", j), 32'(m0_ready), 0);
            tick();
        end
        check_eq("t6_expire", 32'(m0_ready), 1);
        check_eq("t6_expire_rdata", m0_rdata, 32'hDEAD_BEEF);
        tick();
        m0_valid = 0; m1_valid = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
